// File: rtl/power_pulsing_sequencer.sv
// Power-pin sequencer: ramps channel enables up in ascending and down in descending
// order with a programmable step delay, or forces every pin on when pulsing is disabled.

module power_pin_mux (
  input  logic mask,
  input  logic seq,
  output logic pin
);
  // Unpulsed channels stay powered no matter where the sequence is.
  assign pin = mask ? seq : 1'b1;
endmodule

module power_pulsing_sequencer #(
  parameter int CHANNELS    = 4,
  parameter int DELAY_WIDTH = 16
) (
  input  logic                   Clk,
  input  logic                   reset_n,
  input  logic                   PowerPulsingPinEnable,
  input  logic                   PowerOnRequest,
  input  logic [CHANNELS-1:0]    ChannelMask,
  input  logic [DELAY_WIDTH-1:0] StepDelay,
  output logic [CHANNELS-1:0]    PwrOn,
  output logic                   AllOn,
  output logic                   AllOff,
  output logic                   Busy
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(CHANNELS - 1);

  typedef enum logic [2:0] {FORCED, OFF, RAMP_UP, ON, RAMP_DOWN} state_t;

  state_t                 state, stateNext;
  logic [CHANNELS-1:0]    seq, seqNext;
  logic [IDX_W-1:0]       idx, idxNext, idxInc, idxDec;
  logic [DELAY_WIDTH-1:0] cnt, cntNext;
  logic                   stepDone;

  assign idxInc   = idx + 1'b1;
  assign idxDec   = idx - 1'b1;
  assign stepDone = (cnt == StepDelay);

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      state  <= FORCED;
      seq    <= '1;
      idx    <= '0;
      cnt    <= '0;
      AllOn  <= 1'b1;
      AllOff <= 1'b0;
      Busy   <= 1'b0;
    end else begin
      state  <= stateNext;
      seq    <= seqNext;
      idx    <= idxNext;
      cnt    <= cntNext;
      AllOn  <= (stateNext == FORCED) || (stateNext == ON);
      AllOff <= (stateNext == OFF);
      Busy   <= (stateNext == RAMP_UP) || (stateNext == RAMP_DOWN);
    end
  end

  always_comb begin
    stateNext = state;
    seqNext   = seq;
    idxNext   = idx;
    cntNext   = cnt;
    if (!PowerPulsingPinEnable) begin
      stateNext = FORCED;
      seqNext   = '1;
      idxNext   = '0;
      cntNext   = '0;
    end else begin
      case (state)
        FORCED: stateNext = ON;
        OFF: if (PowerOnRequest) begin
          seqNext[0] = 1'b1;
          idxNext    = '0;
          cntNext    = '0;
          stateNext  = (CHANNELS == 1) ? ON : RAMP_UP;
        end
        RAMP_UP: begin
          // A reversal undoes the current channel and beats any coincident step.
          if (!PowerOnRequest) begin
            seqNext[idx] = 1'b0;
            cntNext      = '0;
            stateNext    = (idx == '0) ? OFF : RAMP_DOWN;
          end else if (stepDone) begin
            idxNext         = idxInc;
            seqNext[idxInc] = 1'b1;
            cntNext         = '0;
            if (idxInc == LAST) stateNext = ON;
          end else begin
            cntNext = cnt + 1'b1;
          end
        end
        ON: if (!PowerOnRequest) begin
          idxNext       = LAST;
          seqNext[LAST] = 1'b0;
          cntNext       = '0;
          stateNext     = (CHANNELS == 1) ? OFF : RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (PowerOnRequest) begin
            seqNext[idx] = 1'b1;
            cntNext      = '0;
            stateNext    = (idx == LAST) ? ON : RAMP_UP;
          end else if (stepDone) begin
            idxNext         = idxDec;
            seqNext[idxDec] = 1'b0;
            cntNext         = '0;
            if (idxDec == '0) stateNext = OFF;
          end else begin
            cntNext = cnt + 1'b1;
          end
        end
        default: stateNext = FORCED;
      endcase
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : gPin
    power_pin_mux uPin (
      .mask (ChannelMask[k]),
      .seq  (seq[k]),
      .pin  (PwrOn[k])
    );
  end

endmodule
